// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// Define PIPE_STAGE_STATS_EN to add the saturating stall and bubble counters.
module pipe_stage_skid #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]  o_stall_cnt,
    output logic [CNT_W-1:0]  o_bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } state_t;

    state_t            state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
    logic              valid_q, valid_d;
    logic              ready_q, ready_d;
    logic              accept;
    logic              drain;

    assign accept = i_valid & ready_q;
    assign drain  = valid_q & i_ready;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (i_flush) begin
            // Flush drops held entries and anything offered; payload registers keep their contents.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_ctrl_d = i_ctrl;
                        main_data_d = i_data;
                        state_d     = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_ctrl_d = i_ctrl;
                        main_data_d = i_data;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end else if (accept) begin
                        skid_ctrl_d = i_ctrl;
                        skid_data_d = i_data;
                        state_d     = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        state_d     = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        // Outputs are registered from the next state so they depend on state alone.
        valid_d    = (state_d != ST_EMPTY);
        ready_d    = (state_d != ST_FULL);
        out_ctrl_d = valid_d ? main_ctrl_d : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            out_ctrl_q  <= '0;
            valid_q     <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            out_ctrl_q  <= out_ctrl_d;
            valid_q     <= valid_d;
            ready_q     <= ready_d;
        end
    end

    assign o_valid = valid_q;
    assign o_ready = ready_q;
    assign o_ctrl  = out_ctrl_q;
    assign o_data  = main_data_q;

`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Both counters saturate; a flush cycle is counted like any other.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (valid_q && !i_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (!valid_q && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign o_stall_cnt  = stall_cnt_q;
    assign o_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios plus a random run
// against a queue-based model of the held entries.
module tb_pipe_stage_skid;

    localparam int CTRL_W = 16;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              i_clk = 1'b0;
    logic              i_reset = 1'b1;
    logic              i_valid = 1'b0;
    logic              o_ready;
    logic [CTRL_W-1:0] i_ctrl = '0;
    logic [DATA_W-1:0] i_data = '0;
    logic              i_flush = 1'b0;
    logic              o_valid;
    logic              i_ready = 1'b1;
    logic [CTRL_W-1:0] o_ctrl;
    logic [DATA_W-1:0] o_data;
`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0]  o_stall_cnt;
    logic [CNT_W-1:0]  o_bubble_cnt;
`endif

    always #5 i_clk = ~i_clk;

    pipe_stage_skid #(
        .CTRL_W(CTRL_W),
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_ctrl (i_ctrl),
        .i_data (i_data),
        .i_flush(i_flush),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_ctrl (o_ctrl),
        .o_data (o_data)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .o_stall_cnt (o_stall_cnt),
        .o_bubble_cnt(o_bubble_cnt)
`endif
    );

    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } entry_t;

    // Model: FIFO of entries the stage holds (at most two), last presented data, counters.
    entry_t            mq[$];
    logic [DATA_W-1:0] m_last = '0;
    int                m_stall = 0;
    int                m_bubble = 0;
    int                n_checks = 0;
    int                n_fail = 0;

    // Advance one clock: update the model from the inputs being driven, then sample #1 after the edge.
    task automatic cycle();
        bit acc, drn;
        entry_t e;
        acc = i_valid && (mq.size() < 2);
        drn = (mq.size() > 0) && i_ready;
        e.c = i_ctrl;
        e.d = i_data;
        if (i_reset) begin
            mq.delete();
            m_last   = '0;
            m_stall  = 0;
            m_bubble = 0;
        end else begin
            if (mq.size() > 0 && !i_ready && m_stall < CNT_MAX) m_stall++;
            if (mq.size() == 0 && m_bubble < CNT_MAX) m_bubble++;
            if (i_flush) begin
                mq.delete();
            end else begin
                if (drn) void'(mq.pop_front());
                if (acc) mq.push_back(e);
            end
        end
        if (mq.size() > 0) m_last = mq[0].d;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        cycle();
        cycle();
        i_reset = 1'b0;
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b want=0", o_valid); end
        n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%0b want=1", o_ready); end
        n_checks++; if (o_ctrl !== '0) begin n_fail++; $display("FAIL reset_ctrl got=%h want=0", o_ctrl); end
        n_checks++; if (o_data !== '0) begin n_fail++; $display("FAIL reset_data got=%h want=0", o_data); end
        for (int k = 1; k <= 3; k++) begin
            cycle();
            n_checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin n_fail++; $display("FAIL idle_handshake got v=%0b r=%0b want v=0 r=1", o_valid, o_ready); end
`ifdef PIPE_STAGE_STATS_EN
            n_checks++; if (o_bubble_cnt !== CNT_W'(k)) begin n_fail++; $display("FAIL idle_bubble_cnt got=%0d want=%0d", o_bubble_cnt, k); end
`endif
        end
        $display("reset/idle: o_valid=%0b o_ready=%0b", o_valid, o_ready);
    endtask

    task automatic test_stream();
        logic [DATA_W-1:0] dv[4];
        i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            dv[k]   = $urandom;
            i_valid = 1'b1;
            i_ctrl  = CTRL_W'(k + 1);
            i_data  = dv[k];
            cycle();
            n_checks++; if (o_valid !== 1'b1 || o_ctrl !== CTRL_W'(k + 1) || o_data !== dv[k]) begin
                n_fail++; $display("FAIL stream_out got v=%0b ctrl=%h data=%h want v=1 ctrl=%h data=%h", o_valid, o_ctrl, o_data, k + 1, dv[k]);
            end
            n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready got=%0b want=1", o_ready); end
            $display("stream: ctrl=%h data=%h", o_ctrl, o_data);
        end
        i_valid = 1'b0;
        cycle();
        n_checks++; if (o_valid !== 1'b0 || o_ctrl !== '0 || o_data !== dv[3]) begin
            n_fail++; $display("FAIL stream_drain got v=%0b ctrl=%h data=%h want v=0 ctrl=0 data=%h", o_valid, o_ctrl, o_data, dv[3]);
        end
    endtask

    task automatic test_skid();
        logic [DATA_W-1:0] da, db;
        da = $urandom;
        db = $urandom;
        i_ready = 1'b1; i_valid = 1'b1; i_ctrl = 16'h00A0; i_data = da;
        cycle();
        i_ready = 1'b0; i_ctrl = 16'h00B0; i_data = db;
        cycle();
        n_checks++; if (o_ready !== 1'b0 || o_data !== da || o_ctrl !== 16'h00A0) begin
            n_fail++; $display("FAIL skid_full got r=%0b ctrl=%h data=%h want r=0 ctrl=00a0 data=%h", o_ready, o_ctrl, o_data, da);
        end
        i_valid = 1'b0;
        cycle();
        cycle();
        n_checks++; if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_data !== da) begin
            n_fail++; $display("FAIL skid_hold got v=%0b r=%0b data=%h want v=1 r=0 data=%h", o_valid, o_ready, o_data, da);
        end
`ifdef PIPE_STAGE_STATS_EN
        n_checks++; if (o_stall_cnt !== CNT_W'(3)) begin n_fail++; $display("FAIL skid_stall_cnt got=%0d want=3", o_stall_cnt); end
`endif
        i_ready = 1'b1;
        cycle();
        n_checks++; if (o_valid !== 1'b1 || o_ctrl !== 16'h00B0 || o_data !== db || o_ready !== 1'b1) begin
            n_fail++; $display("FAIL skid_drain_b got v=%0b r=%0b ctrl=%h data=%h want v=1 r=1 ctrl=00b0 data=%h", o_valid, o_ready, o_ctrl, o_data, db);
        end
        cycle();
        n_checks++; if (o_valid !== 1'b0 || o_ctrl !== '0) begin n_fail++; $display("FAIL skid_empty got v=%0b ctrl=%h want v=0 ctrl=0", o_valid, o_ctrl); end
        $display("skid: A=%h B=%h drained in order", da, db);
    endtask

    task automatic test_flush();
        i_ready = 1'b0; i_valid = 1'b1; i_ctrl = 16'h0011; i_data = $urandom;
        cycle();
        i_ctrl = 16'h0022; i_data = $urandom;
        cycle();
        i_flush = 1'b1; i_ctrl = 16'h00CC; i_data = $urandom;
        cycle();
        i_flush = 1'b0;
        n_checks++; if (o_valid !== 1'b0 || o_ctrl !== '0 || o_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_out got v=%0b r=%0b ctrl=%h want v=0 r=1 ctrl=0", o_valid, o_ready, o_ctrl);
        end
        i_valid = 1'b0; i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_checks++; if (o_valid !== 1'b0 || o_ctrl !== '0) begin n_fail++; $display("FAIL flush_no_c got v=%0b ctrl=%h want v=0 ctrl=0", o_valid, o_ctrl); end
        end
        $display("flush: o_valid=%0b o_ready=%0b", o_valid, o_ready);
    endtask

    task automatic test_reset_mid();
        i_ready = 1'b0; i_valid = 1'b1; i_ctrl = 16'h0033; i_data = $urandom;
        cycle();
        cycle();
        i_reset = 1'b1;
        cycle();
        i_reset = 1'b0; i_valid = 1'b0;
        n_checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_ctrl !== '0 || o_data !== '0) begin
            n_fail++; $display("FAIL reset_mid got v=%0b r=%0b ctrl=%h data=%h want 0/1/0/0", o_valid, o_ready, o_ctrl, o_data);
        end
`ifdef PIPE_STAGE_STATS_EN
        n_checks++; if (o_stall_cnt !== '0 || o_bubble_cnt !== '0) begin
            n_fail++; $display("FAIL reset_mid_cnt got stall=%0d bubble=%0d want 0 0", o_stall_cnt, o_bubble_cnt);
        end
`endif
        i_valid = 1'b1; i_ready = 1'b1; i_ctrl = 16'h0044; i_data = $urandom;
        cycle();
        i_valid = 1'b0; i_ready = 1'b0;
        for (int k = 0; k < CNT_MAX + 2; k++) cycle();
        n_checks++; if (o_valid !== 1'b1 || o_ctrl !== 16'h0044) begin n_fail++; $display("FAIL sat_hold got v=%0b ctrl=%h want v=1 ctrl=0044", o_valid, o_ctrl); end
`ifdef PIPE_STAGE_STATS_EN
        n_checks++; if (o_stall_cnt !== CNT_W'(CNT_MAX)) begin n_fail++; $display("FAIL stall_saturate got=%0d want=%0d", o_stall_cnt, CNT_MAX); end
`endif
        i_ready = 1'b1;
        cycle();
        $display("reset_mid/saturation done");
    endtask

    task automatic test_random();
        logic [CTRL_W-1:0] exp_ctrl;
        for (int n = 0; n < 400; n++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 2) != 0);
            i_flush = ($urandom_range(0, 29) == 0);
            i_reset = ($urandom_range(0, 79) == 0);
            i_ctrl  = CTRL_W'($urandom);
            i_data  = $urandom;
            cycle();
            exp_ctrl = (mq.size() > 0) ? mq[0].c : '0;
            n_checks++; if (o_valid !== (mq.size() > 0) || o_ready !== (mq.size() < 2)) begin
                n_fail++; $display("FAIL rand_handshake n=%0d got v=%0b r=%0b want v=%0b r=%0b", n, o_valid, o_ready, mq.size() > 0, mq.size() < 2);
            end
            n_checks++; if (o_ctrl !== exp_ctrl || o_data !== m_last) begin
                n_fail++; $display("FAIL rand_payload n=%0d got ctrl=%h data=%h want ctrl=%h data=%h", n, o_ctrl, o_data, exp_ctrl, m_last);
            end
`ifdef PIPE_STAGE_STATS_EN
            n_checks++; if (o_stall_cnt !== CNT_W'(m_stall) || o_bubble_cnt !== CNT_W'(m_bubble)) begin
                n_fail++; $display("FAIL rand_cnt n=%0d got stall=%0d bubble=%0d want %0d %0d", n, o_stall_cnt, o_bubble_cnt, m_stall, m_bubble);
            end
`endif
        end
        i_reset = 1'b0; i_flush = 1'b0; i_valid = 1'b0;
        $display("random: 400 cycles compared against model");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Generic, parametrised pipeline stage register with a valid/ready handshake and a two-entry skid buffer. It carries a control bundle and a data bundle between adjacent CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It replaces the fixed per-stage registers with one reusable block that supports stall back-pressure, flush with bubble insertion, and optional stall/bubble statistics. Control fields are zeroed whenever no valid entry is presented, so downstream stages see a NOP.

## Interface
Parameters:
- CTRL_W, 16, width of control-line bundle (zeroed on bubble)
- DATA_W, 128, width of data bundle (operands, immediate, register indices, BDS, ...)
- CNT_W, 16, width of statistics counters (only used with PIPE_STAGE_STATS_EN)

Ports:
- i_clk  input  1  clock; all logic on rising edge
- i_reset  input  1  synchronous, active-high reset
- i_valid  input  1  upstream entry valid
- o_ready  output  1  stage can accept; registered, depends only on state
- i_ctrl  input  CTRL_W  upstream control lines
- i_data  input  DATA_W  upstream data
- i_flush  input  1  synchronous flush; discards all held entries
- o_valid  output  1  entry presented downstream
- i_ready  input  1  downstream accepts (0 = stall)
- o_ctrl  output  CTRL_W  control lines; all zero when o_valid=0
- o_data  output  DATA_W  data; holds last value when o_valid=0
- o_stall_cnt  output  CNT_W  cycles with o_valid=1 and i_ready=0 (macro only)
- o_bubble_cnt  output  CNT_W  cycles with o_valid=0 (macro only)

## Operation
- Accept = i_valid & o_ready. Drain = o_valid & i_ready.
- Storage: a main register (drives outputs) and a skid register.
- States: EMPTY (none held), ONE (main valid), FULL (main and skid valid).
- EMPTY: on accept, load main from inputs and go to ONE. Otherwise stay.
- ONE, accept and drain: load main from inputs and stay in ONE.
- ONE, drain only: go to EMPTY.
- ONE, accept only: load skid from inputs and go to FULL.
- ONE, neither: hold.
- FULL: o_ready=0. On drain, copy skid to main and go to ONE. Otherwise hold.
- o_valid = (state != EMPTY). o_ready = (state != FULL).
- o_ctrl = main control when o_valid, else 0. o_data = main data always.
- Flush: next state EMPTY regardless of accept or drain in the same cycle. Any input offered that cycle is dropped. Data registers are not cleared.
- Priority: i_reset > i_flush > handshake.

## Timing
- Reset values: state EMPTY, o_valid=0, o_ready=1, o_ctrl=0, o_data=0, main/skid=0, counters=0.
- Latency: an entry accepted in cycle N is on the outputs in cycle N+1.
- Throughput: 1 entry/cycle while i_ready=1. The skid absorbs the one extra entry accepted during the cycle i_ready falls.
- o_ready falls the cycle after the skid fills and rises the cycle after a drain from FULL.
- After flush (or reset mid-operation): o_valid=0 and o_ready=1 in the next cycle.
- Ordering is preserved: the skid entry is always presented after main.
- Counters saturate at 2^CNT_W-1. They are cleared only by reset, not by flush.
- A flush cycle itself is counted per the o_valid/i_ready values seen that cycle.

## Configuration
- PIPE_STAGE_STATS_EN defined: o_stall_cnt and o_bubble_cnt ports and their counters exist.
- PIPE_STAGE_STATS_EN undefined: the ports are absent and no counter logic is built. Handshake behaviour is identical either way.

## Test plan
- Reset, then idle: o_valid=0, o_ready=1, o_ctrl=0, o_data=0. With stats, o_bubble_cnt counts 1,2,3...
- Stream ctrl=0x0001..0x0004 with i_valid=1, i_ready=1: outputs appear one cycle later, back-to-back, in order, o_ready stays 1.
- Accept A, B; hold i_ready=0 for 3 cycles: o_data=A held, B in skid, o_ready=0 from the cycle after B. With stats, o_stall_cnt=3. Raise i_ready: A then B drain in order, o_ready returns to 1.
- Flush while FULL and i_valid=1 with C: next cycle o_valid=0, o_ctrl=0, o_ready=1, and C never appears.
- Assert i_reset during an active stream with FULL: next cycle all outputs at reset values. Set CNT_W=2 and stall 5 cycles: o_stall_cnt saturates at 3.
